// File: rtl/ptm_seq_scan.sv
// ptm_seq_scan: programmable bit-pattern scanner over a memory-resident stream.
// Word 0 holds the stream length N. Bit 0 of words 1..N is the stream itself.
// The block counts occurrences of a pattern of up to PATW bits, either
// overlapping or non-overlapping. It pulses flag_o on every match and shows a
// saturating count on result_o while fin_o is high.
module ptm_seq_scan #(
  parameter int DATAW = 10,
  parameter int ADDRW = 10,
  parameter int PATW  = 8,
  parameter int CNTW  = 10,
  parameter int LENW  = $clog2(PATW+1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [PATW-1:0]  pat_i,
  input  logic [LENW-1:0]  pat_len_i,
  input  logic             overlap_i,
  input  logic [DATAW-1:0] data_i,
  output logic             en_o,
  output logic [ADDRW-1:0] addr_o,
  output logic             flag_o,
  output logic             fin_o,
  output logic [CNTW-1:0]  result_o
);

  // The fill counter and the effective length both need to hold PATW.
  localparam int FILLW = $clog2(PATW+1);
  localparam logic [PATW:0] ONE = 1;

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_LEN, S_SCAN, S_DONE} state_e;

  state_e           state_q, state_d;
  logic             en_q, en_d;
  logic [ADDRW-1:0] addr_q, addr_d;
  logic             flag_q, flag_d;
  logic             fin_q, fin_d;
  logic [CNTW-1:0]  res_q, res_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [PATW-1:0]  win_q, win_d;
  logic [FILLW-1:0] fill_q, fill_d;
  logic [PATW-1:0]  pat_q, pat_d;
  logic [FILLW-1:0] len_q, len_d;
  logic             ovl_q, ovl_d;
  logic [ADDRW-1:0] n_q, n_d;
  logic [ADDRW-1:0] k_q, k_d;

  logic [FILLW-1:0] len_eff;
  logic [PATW-1:0]  win_sh;
  logic [FILLW-1:0] fill_inc;
  logic [PATW:0]    mask_w;
  logic             hit;
  logic [CNTW-1:0]  cnt_inc;
  logic [ADDRW-1:0] n_cur;
  logic [ADDRW:0]   nxt;
  logic             nxt_ok;

  // Only the low ADDRW bits of word 0 and bit 0 of stream words carry meaning.
  logic unused_data;
  assign unused_data = ^data_i;

  // Match datapath: shifted window, saturating fill, masked compare, next address.
  always_comb begin
    len_eff  = (32'(pat_len_i) > PATW) ? FILLW'(PATW) : FILLW'(pat_len_i);
    win_sh   = (win_q << 1) | PATW'(data_i[0]);
    fill_inc = (fill_q == FILLW'(PATW)) ? fill_q : fill_q + 1'b1;
    mask_w   = (ONE << len_q) - ONE;
    hit      = (len_q != '0) && (fill_inc >= len_q) &&
               (((win_sh ^ pat_q) & mask_w[PATW-1:0]) == '0);
    cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    // In LEN the length arrives on data_i this cycle; later it is held in n_q.
    n_cur    = (state_q == S_LEN) ? data_i[ADDRW-1:0] : n_q;
    // Extra bit so that N = 2^ADDRW-1 does not wrap the address comparison.
    nxt      = {1'b0, addr_q} + 1'b1;
    nxt_ok   = (nxt <= {1'b0, n_cur});
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    en_d    = en_q;
    addr_d  = addr_q;
    flag_d  = 1'b0;
    fin_d   = fin_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    win_d   = win_q;
    fill_d  = fill_q;
    pat_d   = pat_q;
    len_d   = len_q;
    ovl_d   = ovl_q;
    n_d     = n_q;
    k_d     = k_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_REQ;
          en_d    = 1'b1;
          addr_d  = '0;
          pat_d   = pat_i;
          len_d   = len_eff;
          ovl_d   = overlap_i;
          cnt_d   = '0;
          win_d   = '0;
          fill_d  = '0;
        end
      end
      S_REQ: begin
        // Word 1 is prefetched before N is known so the scan starts without a bubble.
        state_d = S_LEN;
        en_d    = 1'b1;
        addr_d  = ADDRW'(1);
      end
      S_LEN: begin
        n_d = data_i[ADDRW-1:0];
        k_d = ADDRW'(1);
        if (data_i[ADDRW-1:0] == '0) begin
          state_d = S_DONE;
          en_d    = 1'b0;
          fin_d   = 1'b1;
          res_d   = cnt_q;
        end else begin
          state_d = S_SCAN;
          en_d    = nxt_ok;
          if (nxt_ok) addr_d = nxt[ADDRW-1:0];
        end
      end
      S_SCAN: begin
        win_d  = win_sh;
        // Non-overlapping mode: bits at or before this match may not be reused.
        fill_d = (hit && !ovl_q) ? '0 : fill_inc;
        if (hit) begin
          cnt_d  = cnt_inc;
          flag_d = 1'b1;
        end
        en_d = nxt_ok;
        if (nxt_ok) addr_d = nxt[ADDRW-1:0];
        if (k_q == n_q) begin
          state_d = S_DONE;
          fin_d   = 1'b1;
          res_d   = hit ? cnt_inc : cnt_q;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      S_DONE: begin
        // A held start keeps the result on display; restart needs a low cycle first.
        if (!start_i) begin
          state_d = S_IDLE;
          fin_d   = 1'b0;
          res_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      en_q    <= 1'b0;
      addr_q  <= '0;
      flag_q  <= 1'b0;
      fin_q   <= 1'b0;
      res_q   <= '0;
      cnt_q   <= '0;
      win_q   <= '0;
      fill_q  <= '0;
      pat_q   <= '0;
      len_q   <= '0;
      ovl_q   <= 1'b0;
      n_q     <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      addr_q  <= addr_d;
      flag_q  <= flag_d;
      fin_q   <= fin_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      win_q   <= win_d;
      fill_q  <= fill_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      ovl_q   <= ovl_d;
      n_q     <= n_d;
      k_q     <= k_d;
    end
  end

  assign en_o     = en_q;
  assign addr_o   = addr_q;
  assign flag_o   = flag_q;
  assign fin_o    = fin_q;
  assign result_o = res_q;

endmodule

// File: tb/tb_ptm_seq_scan.sv
// Testbench for ptm_seq_scan. A default-sized instance covers the main scans.
// A PATW=1, CNTW=2 instance covers pattern-length clamping and count saturation.
// Expected flag and fin events go into a queue when a scan is issued, and a
// monitor pops and checks them whenever either instance shows flag or a fin edge.
module tb_ptm_seq_scan;

  logic clk = 1'b0;
  logic rst_n;

  // default instance signals
  logic       start0, ovl0, en0, flag0, fin0;
  logic [7:0] pat0;
  logic [3:0] pat_len0;
  logic [9:0] data0, addr0, result0;
  // small instance signals
  logic       start1, ovl1, en1, flag1, fin1;
  logic [0:0] pat1;
  logic [2:0] pat_len1;
  logic [9:0] data1, addr1;
  logic [1:0] result1;

  logic [9:0] mem0 [0:1023];
  logic [9:0] mem1 [0:1023];

  int cyc = 0;
  int c0 [2];
  int nchk = 0;
  int nerr = 0;

  typedef struct {int id; int kind; int cyc; int res;} ev_t;
  ev_t exp_q[$];

  ptm_seq_scan dut0 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start0), .pat_i(pat0), .pat_len_i(pat_len0),
    .overlap_i(ovl0), .data_i(data0), .en_o(en0), .addr_o(addr0), .flag_o(flag0),
    .fin_o(fin0), .result_o(result0)
  );

  ptm_seq_scan #(.DATAW(10), .ADDRW(10), .PATW(1), .CNTW(2), .LENW(3)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start1), .pat_i(pat1), .pat_len_i(pat_len1),
    .overlap_i(ovl1), .data_i(data1), .en_o(en1), .addr_o(addr1), .flag_o(flag1),
    .fin_o(fin1), .result_o(result1)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // synchronous ROM models
  always @(posedge clk) if (en0) data0 <= mem0[addr0];
  always @(posedge clk) if (en1) data1 <= mem1[addr1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic mon_ev(input int d, input int k, input int r);
    ev_t e;
    int rel;
    rel = cyc - c0[d];
    if (exp_q.size() == 0) begin
      nchk++;
      nerr++;
      $display("FAIL sb_unexpected: dut%0d kind %0d at cycle %0d, nothing expected", d, k, rel);
    end else begin
      e = exp_q.pop_front();
      chk("sb_dut", d, e.id);
      chk("sb_kind", k, e.kind);
      chk(k == 1 ? "fin_cycle" : "flag_cycle", rel, e.cyc);
      if (k == 1) chk("result", r, e.res);
    end
  endtask

  // monitor: compare every flag pulse and fin rise against the queue
  initial begin
    bit fp0, fp1;
    fp0 = 1'b0;
    fp1 = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (flag0) mon_ev(0, 0, 0);
        if (fin0 && !fp0) mon_ev(0, 1, int'(result0));
        if (flag1) mon_ev(1, 0, 0);
        if (fin1 && !fp1) mon_ev(1, 1, int'(result1));
      end
      fp0 = fin0;
      fp1 = fin1;
    end
  end

  task automatic load_mem(input int id, input int n, input logic [31:0] bits);
    if (id == 0) mem0[0] = 10'(n); else mem1[0] = 10'(n);
    for (int k = 1; k <= n; k++) begin
      if (id == 0) mem0[k] = {9'h155, bits[k-1]};
      else         mem1[k] = {9'h155, bits[k-1]};
    end
  endtask

  // Present start for one cycle (c0) and queue the hand-computed events.
  task automatic issue(input int id, input int n, input logic [7:0] patv, input int plen,
                       input bit ovl, input logic [63:0] fmap, input int res, input bit push_fin);
    @(negedge clk);
    if (id == 0) begin
      pat0 = patv; pat_len0 = 4'(plen); ovl0 = ovl; start0 = 1'b1;
    end else begin
      pat1 = patv[0]; pat_len1 = 3'(plen); ovl1 = ovl; start1 = 1'b1;
    end
    c0[id] = cyc;
    for (int c = 0; c < 64; c++)
      if (fmap[c]) exp_q.push_back(ev_t'{id, 0, c, 0});
    if (push_fin) exp_q.push_back(ev_t'{id, 1, n + 3, res});
  endtask

  // After acceptance the pattern inputs must be ignored, so disturb them.
  task automatic scramble(input int id, input bit hold);
    if (id == 0) begin
      if (!hold) start0 = 1'b0;
      pat0 = ~pat0; pat_len0 = ~pat_len0; ovl0 = ~ovl0;
    end else begin
      if (!hold) start1 = 1'b0;
      pat1 = ~pat1; pat_len1 = ~pat_len1; ovl1 = ~ovl1;
    end
  endtask

  // Follow a scan cycle by cycle: en/addr schedule and fin exactly at N+3.
  task automatic track(input int id, input int n, input bit hold);
    int top;
    logic e, f;
    logic [9:0] a;
    top = (n + 1 > 2) ? n + 1 : 2;
    for (int r = 1; r <= n + 3; r++) begin
      @(negedge clk);
      if (r == 1) scramble(id, hold);
      e = id ? en1 : en0;
      a = id ? addr1 : addr0;
      f = id ? fin1 : fin0;
      chk($sformatf("en_c%0d_dut%0d", r, id), e, (r <= top) ? 1 : 0);
      if (r <= top) chk($sformatf("addr_c%0d_dut%0d", r, id), a, r - 1);
      chk($sformatf("fin_c%0d_dut%0d", r, id), f, (r == n + 3) ? 1 : 0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    start0 = 1'b0; pat0 = '0; pat_len0 = '0; ovl0 = 1'b0;
    start1 = 1'b0; pat1 = '0; pat_len1 = '0; ovl1 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_en", en0, 0);
    chk("rst_addr", addr0, 0);
    chk("rst_flag", flag0, 0);
    chk("rst_fin", fin0, 0);
    chk("rst_result", result0, 0);
    chk("rst_fin1", fin1, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_fin", fin0, 0);

    // legacy 7-bit pattern 1010011, single match on word 7
    load_mem(0, 7, 32'h65);
    issue(0, 7, 8'b0101_0011, 7, 1'b1, 64'h400, 1, 1'b1);
    track(0, 7, 1'b0);

    // 101 over 1,0,1,0,1 overlapping: matches on words 3 and 5
    load_mem(0, 5, 32'h15);
    issue(0, 5, 8'b0000_0101, 3, 1'b1, 64'h140, 2, 1'b1);
    track(0, 5, 1'b0);

    // same stream non-overlapping: only word 3
    issue(0, 5, 8'b0000_0101, 3, 1'b0, 64'h040, 1, 1'b1);
    track(0, 5, 1'b0);

    // empty stream
    load_mem(0, 0, 32'h0);
    issue(0, 0, 8'b0000_0101, 3, 1'b1, 64'h0, 0, 1'b1);
    track(0, 0, 1'b0);

    // clamp pat_len 4 -> 1 and saturate a 2-bit count at 3
    load_mem(1, 5, 32'h1F);
    issue(1, 5, 8'h01, 4, 1'b1, 64'h1F0, 3, 1'b1);
    track(1, 5, 1'b0);

    // reset in cycle 5 of an N=20 scan
    load_mem(0, 20, 32'hFFFFF);
    issue(0, 20, 8'b0000_0111, 3, 1'b1, 64'h0, 0, 1'b0);
    @(negedge clk);
    start0 = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_en", en0, 0);
    chk("midrst_addr", addr0, 0);
    chk("midrst_flag", flag0, 0);
    chk("midrst_fin", fin0, 0);
    chk("midrst_result", result0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // fresh scan: 1,1,1,0 with 111 gives exactly one match on word 3
    load_mem(0, 4, 32'h7);
    issue(0, 4, 8'b0000_0111, 3, 1'b1, 64'h040, 1, 1'b1);
    track(0, 4, 1'b0);

    // start held through DONE: no rescan, result held
    load_mem(0, 5, 32'h15);
    issue(0, 5, 8'b0000_0101, 3, 1'b1, 64'h140, 2, 1'b1);
    track(0, 5, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("hold_fin_%0d", i), fin0, 1);
      chk($sformatf("hold_result_%0d", i), result0, 2);
      chk($sformatf("hold_en_%0d", i), en0, 0);
    end
    start0 = 1'b0;
    issue(0, 5, 8'b0000_0101, 3, 1'b1, 64'h140, 2, 1'b1);
    chk("reidle_fin", fin0, 0);
    chk("reidle_result", result0, 0);
    track(0, 5, 1'b0);

    repeat (3) @(negedge clk);
    chk("sb_drain", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/ptm_seq_scan.md
# ptm_seq_scan

Parametrised pattern-matching scanner, successor to the fixed 7-bit matcher. After a start request it reads a stream length N from memory word 0 and bit 0 of words 1..N from a synchronous ROM. It counts occurrences of a programmable pattern of up to PATW bits, in overlapping or non-overlapping mode. It reports a per-match flag and, on completion, a saturating match count.

## Interface
- DATAW, 10: memory data width
- ADDRW, 10: memory address width; max N = 2^ADDRW-1
- PATW, 8: max pattern length (≥1)
- CNTW, 10: result counter width
- LENW, $clog2(PATW+1): pattern-length field width

- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  level request; sampled in IDLE and DONE
- pat  in  PATW  pattern; pat[L-1] is the first bit in stream order, pat[0] is the last
- pat_len  in  LENW  pattern length L
- overlap  in  1  1 = overlapping matches counted, 0 = non-overlapping
- data  in  DATAW  memory read data
- en  out  1  memory read enable (registered)
- addr  out  ADDRW  memory address (registered)
- flag  out  1  one-cycle pulse per match (registered)
- fin  out  1  scan complete (level)
- result  out  CNTW  match count; valid while fin=1, else 0

## Operation
- Reset (rst=0, any time, including mid-scan): state=IDLE, en=0, addr=0, flag=0, fin=0, result=0, counters/window cleared.
- pat, pat_len and overlap are latched when start is accepted. They are ignored afterwards until the next start.
- Effective L = min(pat_len, PATW). L=0 means no match is ever reported.
- Memory contract: data in cycle t+1 = mem[addr in cycle t] when en=1 in cycle t.
- FSM:
  - IDLE: start=1 -> REQ.
  - REQ: drive addr=0, en=1 -> LEN.
  - LEN: drive addr=1, en=1 (unconditional prefetch). Latch N = data[ADDRW-1:0]. N=0 -> DONE, else -> SCAN.
  - SCAN: consume data[0] of word k, k=1..N. While the next address is ≤ N, issue it with en=1, else en=0. After consuming word N -> DONE.
  - DONE: fin=1, result=count. start=0 -> IDLE. start held high stays in DONE; no restart without a low cycle.
- Matching:
  - Window: PATW-bit shift register, newest bit at [0].
  - Fill counter: saturates at PATW.
  - Per consumed bit: shift in, increment fill.
  - Match when fill ≥ L, L≥1 and window[L-1:0] == pat[L-1:0] after the shift.
- On match:
  - count increments, saturating at 2^CNTW-1.
  - flag pulses.
  - If overlap=0, fill resets to 0. The window is kept but bits older than the match cannot contribute.
- The counter, window and fill are cleared on start acceptance, not on DONE exit. After DONE->IDLE, result returns to 0.
- DATAW wider than ADDRW: upper length bits are ignored.

## Timing
- c0 is the cycle in which start=1 is sampled in IDLE.
- Cycle plan:
  - c1: REQ.
  - c2: LEN.
  - cycle k+2: word k consumed, k=1..N.
  - cycle N+3: first DONE cycle with fin=1 (N=0 gives fin in c3).
- Address k is driven in cycle k+1; en=0 from cycle N+2 onward.
- A match on word k gives flag=1 in cycle k+3 only. A match on word N pulses flag in the same cycle fin rises, and that match is already included in result.
- Total latency from start sample to fin: N+3 cycles.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Legacy pattern: pat=7'b1010011, L=7, overlap=1; mem[0]=7, mem[1..7]=1,0,1,0,0,1,1 -> flag high in cycle 10 only, fin rises cycle 10, result=1.
- Overlap modes: pat=3'b101, L=3; mem[0]=5, bits 1,0,1,0,1. overlap=1 -> flags in cycles 6 and 8, result=2. overlap=0 -> flag in cycle 6 only, result=1.
- Empty stream: mem[0]=0 -> fin in c3, result=0, flag never asserted, en=0 from c3.
- Saturation/clamp: CNTW=2, pat_len=PATW+3 with PATW=1, pat=1; mem[0]=5, all ones -> L=1, five flag pulses, result=3.
- Reset mid-scan: drop rst in cycle 5 of an N=20 scan -> all outputs 0 immediately. A new start then gives a correct result, with no carry-over of count or window.
- Start held: keep start=1 through DONE -> fin stays 1, no rescan. Deassert start for one cycle, then reassert -> IDLE, then a fresh scan with fin after N+3 cycles.
